// File: rtl/seg_pkg.sv
// Shared code type, glyph constants and the A..Z glyph table for the segment scanner.
// Glyphs are active-low with bit 0 = segment a through bit 6 = segment g.
package seg_pkg;

    typedef logic [5:0] code_t;

    localparam code_t      CODE_BLANK         = 6'd26;
    localparam code_t      CODE_FIRST_INVALID = 6'd27;
    localparam logic [6:0] SEG_OFF            = 7'h7F;
    localparam logic [6:0] SEG_DASH           = 7'h3F;

    // Letters A..Z; a few letters (K, M, V, W, X) are approximations on seven segments.
    localparam logic [6:0] LETTER_GLYPH [26] = '{
        7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42, 7'h09, 7'h4F,
        7'h61, 7'h0A, 7'h47, 7'h6A, 7'h2B, 7'h40, 7'h0C, 7'h18, 7'h2F,
        7'h12, 7'h07, 7'h41, 7'h63, 7'h55, 7'h09, 7'h11, 7'h24
    };

endpackage

// File: rtl/seg_code_decode.sv
// Combinational decode of a 6-bit display code into an active-low 7-segment glyph:
// letters for 0..25, dark for the blank code, dash for everything above.
module seg_code_decode
    import seg_pkg::*;
(
    input  code_t      i_code,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = SEG_DASH;
        if (i_code < CODE_BLANK) begin
            o_glyph = LETTER_GLYPH[i_code[4:0]];
        end else if (i_code < CODE_FIRST_INVALID) begin
            o_glyph = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner with frame-boundary (tear-free) data update.
// Define SEG_BLINK_EN to enable per-digit blinking driven by blink_mask.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [NUM_DIGITS*6-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    update_pending
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]                r_presc;
    logic [IW-1:0]                r_idx;
    logic [IW-1:0]                w_idx_nxt;
    code_t [NUM_DIGITS-1:0]       r_act_code;
    code_t [NUM_DIGITS-1:0]       r_pend_code;
    code_t [NUM_DIGITS-1:0]       w_act_code_nxt;
    logic [NUM_DIGITS-1:0]        r_act_blank;
    logic [NUM_DIGITS-1:0]        r_pend_blank;
    logic [NUM_DIGITS-1:0]        w_act_blank_nxt;
    logic                         r_pending;
    logic                         w_tick;
    logic                         w_wrap;
    logic                         w_blink_dark;
    code_t                        w_code;
    logic [6:0]                   w_glyph;
    logic [6:0]                   r_seg;
    logic [NUM_DIGITS-1:0]        r_an;

    assign w_tick    = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_wrap    = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
    assign w_idx_nxt = !w_tick ? r_idx : (w_wrap ? '0 : r_idx + 1'b1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
            r_idx   <= w_idx_nxt;
        end
    end

    // A load landing exactly on the wrap edge bypasses the pending stage.
    always_comb begin
        w_act_code_nxt  = r_act_code;
        w_act_blank_nxt = r_act_blank;
        if (w_wrap && load) begin
            w_act_code_nxt  = data_in;
            w_act_blank_nxt = blank_mask;
        end else if (w_wrap && r_pending) begin
            w_act_code_nxt  = r_pend_code;
            w_act_blank_nxt = r_pend_blank;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_act_code   <= {NUM_DIGITS{CODE_BLANK}};
            r_act_blank  <= '0;
            r_pend_code  <= {NUM_DIGITS{CODE_BLANK}};
            r_pend_blank <= '0;
            r_pending    <= 1'b0;
        end else begin
            r_act_code  <= w_act_code_nxt;
            r_act_blank <= w_act_blank_nxt;
            if (load && !w_wrap) begin
                r_pend_code  <= data_in;
                r_pend_blank <= blank_mask;
                r_pending    <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] r_frame_cnt;
    logic [FW-1:0] w_frame_cnt_nxt;
    logic          r_blink;
    logic          w_blink_nxt;

    always_comb begin
        w_frame_cnt_nxt = r_frame_cnt;
        w_blink_nxt     = r_blink;
        if (w_wrap) begin
            if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                w_frame_cnt_nxt = '0;
                w_blink_nxt     = ~r_blink;
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
            r_blink     <= w_blink_nxt;
        end
    end

    assign w_blink_dark = w_blink_nxt && blink_mask[w_idx_nxt];
`else
    logic w_unused_blink;
    assign w_unused_blink = ^blink_mask;
    assign w_blink_dark   = 1'b0;
`endif

    // Outputs are built from next-state values so they move on the same edge as the index.
    assign w_code = w_act_code_nxt[w_idx_nxt];

    seg_code_decode u_decode (
        .i_code  (w_code),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= SEG_OFF;
            r_an  <= ~NUM_DIGITS'(1);
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << w_idx_nxt);
            r_seg <= (w_act_blank_nxt[w_idx_nxt] || w_blink_dark) ? SEG_OFF : w_glyph;
        end
    end

    assign seg            = r_seg;
    assign an             = r_an;
    assign frame_tick     = w_wrap && rst_n;
    assign update_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (4 digits, REFRESH_DIV=4, BLINK_FRAMES=2).
// Blink checks follow SEG_BLINK_EN when the bench is compiled with it.
`timescale 1ns/1ps
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [23:0] data_in;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;
    logic        update_pending;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [23:0]     data;
        logic [3:0]      blank;
        logic [3:0][6:0] segs;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    vec_t            vecs [4];
    exp_t            sb [$];
    logic [3:0][6:0] prev_segs;

    seg_scan_display #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (load),
        .data_in        (data_in),
        .blank_mask     (blank_mask),
        .blink_mask     (blink_mask),
        .seg            (seg),
        .an             (an),
        .frame_tick     (frame_tick),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic wait_frame_tick();
        int n = 0;
        while (frame_tick !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_frame_tick actual=timeout expected=pulse within 40 cycles");
        end
    endtask

    task automatic do_load(input logic [23:0] d, input logic [3:0] b);
        load       = 1'b1;
        data_in    = d;
        blank_mask = b;
        tick();
        load       = 1'b0;
    endtask

    task automatic goto_mid_frame();
        wait_frame_tick();
        repeat (6) tick();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic push_frame(input logic [3:0][6:0] segs);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            e.an  = ~(4'b0001 << d);
            e.seg = segs[d];
            sb.push_back(e);
        end
    endtask

    // Called on the first cycle of a frame; walks the four digit slots.
    task automatic check_frame();
        exp_t e;
        chk("pending_after_apply", 32'(update_pending), 32'd0);
        for (int d = 0; d < 4; d++) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty actual=0 entries expected=1 entry");
            end else begin
                e = sb.pop_front();
                chk("slot_an", 32'(an), 32'(e.an));
                chk("slot_seg", 32'(seg), 32'(e.seg));
            end
            repeat (4) tick();
        end
    endtask

    initial begin
        logic ft_seen;
        logic [3:0][6:0] segs;

        vecs[0].data = {6'd3, 6'd2, 6'd1, 6'd0};
        vecs[0].blank = 4'b0000;
        vecs[0].segs = {7'h21, 7'h46, 7'h03, 7'h08};
        vecs[1].data = {6'd26, 6'd27, 6'd63, 6'd25};
        vecs[1].blank = 4'b0000;
        vecs[1].segs = {7'h7F, 7'h3F, 7'h3F, 7'h24};
        vecs[2].data = {6'd4, 6'd4, 6'd4, 6'd4};
        vecs[2].blank = 4'b0100;
        vecs[2].segs = {7'h06, 7'h7F, 7'h06, 7'h06};
        vecs[3].data = {6'd15, 6'd7, 6'd18, 6'd14};
        vecs[3].blank = 4'b0001;
        vecs[3].segs = {7'h0C, 7'h09, 7'h12, 7'h7F};

        rst_n      = 1'b0;
        load       = 1'b0;
        data_in    = '0;
        blank_mask = '0;
        blink_mask = '0;
        tick();
        chk("in_reset_seg", 32'(seg), 32'h7F);
        chk("in_reset_an", 32'(an), 32'hE);
        repeat (2) tick();
        rst_n = 1'b1;
        chk("reset_an", 32'(an), 32'hE);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_frame_tick", 32'(frame_tick), 32'd0);
        chk("reset_pending", 32'(update_pending), 32'd0);

        // Free run: digit changes every 4 clocks, wrap pulse every 16.
        for (int n = 1; n <= 32; n++) begin
            tick();
            chk("run_an", 32'(an), 32'(4'(~(4'b0001 << ((n / 4) % 4)))));
            chk("run_seg", 32'(seg), 32'h7F);
            chk("run_frame_tick", 32'(frame_tick), 32'((n % 16) == 15));
        end

        prev_segs = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            goto_mid_frame();
            do_load(vecs[i].data, vecs[i].blank);
            chk("pending_after_load", 32'(update_pending), 32'd1);
            wait_frame_tick();
            chk("pending_at_boundary", 32'(update_pending), 32'd1);
            chk("hold_an", 32'(an), 32'h7);
            chk("hold_seg", 32'(seg), 32'(prev_segs[3]));
            tick();
            push_frame(vecs[i].segs);
            check_frame();
            prev_segs = vecs[i].segs;
        end

        // Last of two loads before the boundary wins.
        goto_mid_frame();
        do_load({6'd0, 6'd0, 6'd0, 6'd0}, 4'b0000);
        do_load({6'd25, 6'd25, 6'd25, 6'd25}, 4'b0000);
        chk("double_load_pending", 32'(update_pending), 32'd1);
        wait_frame_tick();
        tick();
        push_frame({7'h24, 7'h24, 7'h24, 7'h24});
        check_frame();

        // Load on the frame_tick cycle goes straight to the display.
        wait_frame_tick();
        do_load({6'd0, 6'd0, 6'd40, 6'd0}, 4'b0000);
        chk("coincident_pending", 32'(update_pending), 32'd0);
        repeat (4) tick();
        chk("coincident_d1_an", 32'(an), 32'hD);
        chk("coincident_d1_seg", 32'(seg), 32'h3F);
        repeat (4) tick();
        chk("coincident_d2_seg", 32'(seg), 32'h08);

        // Reset while a load is pending.
        goto_mid_frame();
        do_load({6'd3, 6'd2, 6'd1, 6'd0}, 4'b0000);
        chk("pre_reset_pending", 32'(update_pending), 32'd1);
        pulse_reset();
        chk("post_reset_pending", 32'(update_pending), 32'd0);
        chk("post_reset_an", 32'(an), 32'hE);
        chk("post_reset_seg", 32'(seg), 32'h7F);
        ft_seen = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (frame_tick !== 1'b0) ft_seen = 1'b1;
        end
        chk("post_reset_no_early_tick", 32'(ft_seen), 32'd0);
        wait_frame_tick();
        tick();
        push_frame({7'h7F, 7'h7F, 7'h7F, 7'h7F});
        check_frame();

        // Blink on digit 0, blank on digit 2.
        pulse_reset();
        blink_mask = 4'b0001;
        repeat (5) tick();
        do_load({6'd0, 6'd0, 6'd0, 6'd0}, 4'b0100);
        wait_frame_tick();
        tick();
        for (int f = 1; f <= 6; f++) begin
`ifdef SEG_BLINK_EN
            segs[0] = (((f / 2) % 2) == 1) ? 7'h7F : 7'h08;
`else
            segs[0] = 7'h08;
`endif
            segs[1] = 7'h08;
            segs[2] = 7'h7F;
            segs[3] = 7'h08;
            push_frame(segs);
            check_frame();
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles each digit is lit; legal range 2 or more.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period.
REQ-004 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 Port load, input, 1 bit: one-cycle strobe that captures data_in and blank_mask.
REQ-007 Port data_in, input, NUM_DIGITS*6 bits: 6-bit code per digit; digit k occupies bits [6k+5:6k].
REQ-008 Port blank_mask, input, NUM_DIGITS bits: 1 forces digit k dark; captured with load.
REQ-009 Port blink_mask, input, NUM_DIGITS bits: 1 makes digit k blink; sampled live, not captured.
REQ-010 Port seg, output, 7 bits: active-low segments, with bit 0 = a through bit 6 = g.
REQ-011 Port an, output, NUM_DIGITS bits: active-low digit enables; at most one bit is low at any time.
REQ-012 Port frame_tick, output, 1 bit: one-cycle pulse when the scan wraps to digit 0.
REQ-013 Port update_pending, output, 1 bit: high while a captured load waits for a frame boundary.

Function
REQ-014 The prescaler shall count 0..REFRESH_DIV-1 and assert an internal tick at its terminal count, then wrap to 0.
REQ-015 On each tick, the digit index shall advance by one; from NUM_DIGITS-1 it wraps to 0.
REQ-016 On the cycle the index wraps to 0, frame_tick shall pulse high for exactly one clock.
REQ-017 seg and an shall be registered, reflecting the new digit index one clock after the tick (latency 1).
REQ-018 Code decode: codes 0..25 show letters A..Z; code 26 shows blank (7'h7F); codes 27..63 show the dash glyph, seg = 7'h3F (only g lit).
REQ-019 A blanked digit shall drive seg = 7'h7F and keep its an bit low for the slot, so scan timing is unchanged.
REQ-020 Load capture: load=1 shall copy data_in and blank_mask into a pending register and set update_pending.
REQ-021 Frame-boundary apply: when frame_tick fires with update_pending=1, the pending register shall move to the active register and update_pending clears on the same edge (tear-free update).
REQ-022 Repeated load: a load while update_pending=1 shall overwrite the pending register; the last load wins.
REQ-023 Simultaneous load and frame boundary: load coinciding with the frame_tick edge shall write data_in straight to the active register and leave update_pending=0.
REQ-024 NUM_DIGITS=1: the index shall stay 0 and frame_tick shall pulse on every tick.

Reset
REQ-025 rst_n=0 at a clock edge shall set: prescaler 0, digit index 0, update_pending 0, frame_tick 0, blink phase 0.
REQ-026 Reset shall also set all active and pending codes to 26 (blank) and blank_mask to 0.
REQ-027 During reset and on the first clock after release, seg shall be 7'h7F and an = ~1 (digit 0 enabled).
REQ-028 Reset asserted mid-frame or mid-pending shall discard pending data with no further frame_tick.

Configuration
REQ-029 With SEG_BLINK_EN defined: a frame counter shall toggle the blink phase every BLINK_FRAMES frames, and while the phase is 1, digits with blink_mask=1 are forced dark as in REQ-019.
REQ-030 Without SEG_BLINK_EN: the blink_mask port shall remain present but be ignored, and no frame counter shall be synthesised.

Structure
REQ-031 A shared package seg_pkg shall hold the 6-bit code type, the constants CODE_BLANK=26 and CODE_FIRST_INVALID=27, the glyph constants SEG_OFF=7'h7F and SEG_DASH=7'h3F, and the 26-entry letter glyph table.
REQ-032 One combinational sub-module, seg_code_decode (6-bit code in, 7-bit active-low glyph out), shall be instantiated once on the muxed digit code.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-033 Reset then free-run: an shall cycle 1110, 1101, 1011, 0111 every 4 clocks; frame_tick pulses every 16 clocks; seg stays 7'h7F.
REQ-034 Load codes {3,2,1,0} mid-frame: update_pending goes high; digits are unchanged until frame_tick; then digit 0 shows A and digit 3 shows D.
REQ-035 Two loads ({0,0,0,0} then {25,25,25,25}) before the boundary: after frame_tick all digits show Z and update_pending=0.
REQ-036 Load on the frame_tick cycle with code 40 on digit 1: digit 1 shows 7'h3F in that same frame and update_pending stays 0.
REQ-037 Blank_mask=0100 with SEG_BLINK_EN defined and blink_mask=0001: digit 2 is always dark; digit 0 is dark on alternate 2-frame periods; an sequencing is unaffected.
REQ-038 Assert rst_n=0 for 1 cycle while update_pending=1: pending clears, and the next frame still shows blank codes.
